// File: rtl/bcd_alu.sv
// Three-digit BCD add/sub/mul/div; done in cycle 15 (add/sub) or 24 (mul/div) after execute.
// No backpressure: execute is ignored unless idle, and results hold until the next done.
module bcd_alu (
  input  logic       clock,
  input  logic       reset,
  input  logic       execute,
  input  logic [1:0] op_code,
  input  logic [3:0] a1,
  input  logic [3:0] a10,
  input  logic [3:0] a100,
  input  logic [3:0] b1,
  input  logic [3:0] b10,
  input  logic [3:0] b100,
  output logic [3:0] r1,
  output logic [3:0] r10,
  output logic [3:0] r100,
  output logic       negative,
  output logic       overflow,
  output logic       div_zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, CONVERT, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [11:0] a_dig, b_dig;
  logic [3:0]  cnt;
  logic [9:0]  a_bin, b_bin, rem;
  logic [19:0] prod;
  logic [21:0] dd;
  logic        neg_q, ovf_q, dz_q;

  logic        last_step;
  logic [3:0]  a_sel, b_sel;
  logic [9:0]  a_acc_nxt, b_acc_nxt;
  logic [10:0] sum;
  logic [19:0] mul_nxt;
  logic [10:0] rem_sh;
  logic        rem_ge;
  logic [9:0]  rem_nxt, quo_nxt;
  logic [9:0]  res_c;
  logic        neg_c, ovf_c, dz_c;
  logic [21:0] dd_nxt;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One double-dabble iteration over {hundreds, tens, ones, binary}.
  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // Add/sub finish in one COMPUTE cycle; mul/div iterate over ten bits.
  assign last_step = (state == COMPUTE) && ((op_q[1] == 1'b0) || (cnt == 4'd9));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (execute) state_nxt = LOAD;
      LOAD:    if (cnt == 4'd2) state_nxt = COMPUTE;
      COMPUTE: if (last_step) state_nxt = CONVERT;
      CONVERT: if (cnt == 4'd9) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hundreds digit first: acc = acc*10 + digit.
  always_comb begin
    a_sel = (cnt == 4'd0) ? a_dig[11:8] : (cnt == 4'd1) ? a_dig[7:4] : a_dig[3:0];
    b_sel = (cnt == 4'd0) ? b_dig[11:8] : (cnt == 4'd1) ? b_dig[7:4] : b_dig[3:0];
    a_acc_nxt = (a_bin << 3) + (a_bin << 1) + {6'd0, a_sel};
    b_acc_nxt = (b_bin << 3) + (b_bin << 1) + {6'd0, b_sel};
  end

  // Multiply scans B MSB-first; divide shifts the quotient into a_bin.
  always_comb begin
    sum     = {1'b0, a_bin} + {1'b0, b_bin};
    mul_nxt = (prod << 1) + (b_bin[9] ? {10'd0, a_bin} : 20'd0);
    rem_sh  = {rem, a_bin[9]};
    rem_ge  = (rem_sh >= {1'b0, b_bin});
    rem_nxt = rem_ge ? (rem_sh[9:0] - b_bin) : rem_sh[9:0];
    quo_nxt = {a_bin[8:0], rem_ge};
    dd_nxt  = dd_step(dd);
  end

  always_comb begin
    res_c = '0;
    neg_c = 1'b0;
    ovf_c = 1'b0;
    dz_c  = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (sum > 11'd999) ovf_c = 1'b1;
        else               res_c = sum[9:0];
      end
      OP_SUB: begin
        if (a_bin < b_bin) begin
          res_c = b_bin - a_bin;
          neg_c = 1'b1;
        end else begin
          res_c = a_bin - b_bin;
        end
      end
      OP_MUL: begin
        if (mul_nxt > 20'd999) ovf_c = 1'b1;
        else                   res_c = mul_nxt[9:0];
      end
      default: begin
        if (b_bin == 10'd0) dz_c  = 1'b1;
        else                res_c = quo_nxt;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= '0;
      a_dig    <= '0;
      b_dig    <= '0;
      cnt      <= '0;
      a_bin    <= '0;
      b_bin    <= '0;
      rem      <= '0;
      prod     <= '0;
      dd       <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      r1       <= '0;
      r10      <= '0;
      r100     <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (execute) begin
            op_q  <= op_code;
            a_dig <= {clamp9(a100), clamp9(a10), clamp9(a1)};
            b_dig <= {clamp9(b100), clamp9(b10), clamp9(b1)};
            cnt   <= '0;
            a_bin <= '0;
            b_bin <= '0;
            rem   <= '0;
            prod  <= '0;
          end
        end
        LOAD: begin
          a_bin <= a_acc_nxt;
          b_bin <= b_acc_nxt;
          cnt   <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
        end
        COMPUTE: begin
          if (op_q == OP_MUL) begin
            prod  <= mul_nxt;
            b_bin <= {b_bin[8:0], 1'b0};
          end else if (op_q[1]) begin
            rem   <= rem_nxt;
            a_bin <= quo_nxt;
          end
          cnt <= cnt + 4'd1;
          if (last_step) begin
            cnt   <= '0;
            dd    <= {12'd0, res_c};
            neg_q <= neg_c;
            ovf_q <= ovf_c;
            dz_q  <= dz_c;
          end
        end
        CONVERT: begin
          dd  <= dd_nxt;
          cnt <= cnt + 4'd1;
          // Outputs become visible in the DONE cycle alongside the done strobe.
          if (cnt == 4'd9) begin
            cnt      <= '0;
            r100     <= dd_nxt[21:18];
            r10      <= dd_nxt[17:14];
            r1       <= dd_nxt[13:10];
            negative <= neg_q;
            overflow <= ovf_q;
            div_zero <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu.sv
// Directed-vector bench for bcd_alu: result table plus reset/abort and ignored-execute sequences.
module tb_bcd_alu;

  logic       clock = 1'b0;
  logic       reset, execute;
  logic [1:0] op_code;
  logic [3:0] a1, a10, a100, b1, b10, b100;
  logic [3:0] r1, r10, r100;
  logic       negative, overflow, div_zero, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  bcd_alu dut (
    .clock   (clock),
    .reset   (reset),
    .execute (execute),
    .op_code (op_code),
    .a1      (a1),
    .a10     (a10),
    .a100    (a100),
    .b1      (b1),
    .b10     (b10),
    .b100    (b100),
    .r1      (r1),
    .r10     (r10),
    .r100    (r100),
    .negative(negative),
    .overflow(overflow),
    .div_zero(div_zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] r;
    logic        neg;
    logic        ovf;
    logic        dz;
    int          lat;
    bit          disturb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          done_cyc, done_cnt, busy_bad;
    logic [11:0] r_at_done;
    logic [2:0]  f_at_done;
    done_cyc  = -1;
    done_cnt  = 0;
    busy_bad  = 0;
    r_at_done = 'x;
    f_at_done = 'x;
    @(posedge clock); #1;
    op_code = v.op;
    {a100, a10, a1} = v.a;
    {b100, b10, b1} = v.b;
    execute = 1'b1;
    @(negedge clock);
    if (busy !== 1'b0) busy_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      execute = 1'b0;
      // Inputs change after the latch cycle; the operation in flight must not see them.
      {a100, a10, a1} = 12'h888;
      {b100, b10, b1} = 12'h000;
      op_code = ~v.op;
      if (v.disturb && c == 5) begin
        execute = 1'b1;
        op_code = 2'b00;
        {a100, a10, a1} = 12'h002;
        {b100, b10, b1} = 12'h003;
      end
      @(negedge clock);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = c;
          r_at_done = {r100, r10, r1};
          f_at_done = {negative, overflow, div_zero};
        end
      end
      if (busy !== ((c <= v.lat) ? 1'b1 : 1'b0)) busy_bad++;
    end
    chk($sformatf("v%0d latency", idx), done_cyc, v.lat);
    chk($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    chk($sformatf("v%0d busy_profile_errs", idx), busy_bad, 0);
    chk($sformatf("v%0d result", idx), {20'd0, r_at_done}, {20'd0, v.r});
    chk($sformatf("v%0d negative", idx), {31'd0, f_at_done[2]}, {31'd0, v.neg});
    chk($sformatf("v%0d overflow", idx), {31'd0, f_at_done[1]}, {31'd0, v.ovf});
    chk($sformatf("v%0d div_zero", idx), {31'd0, f_at_done[0]}, {31'd0, v.dz});
    chk($sformatf("v%0d result_held", idx), {20'd0, r100, r10, r1}, {20'd0, v.r});
    chk($sformatf("v%0d flags_held", idx), {29'd0, negative, overflow, div_zero},
        {29'd0, v.neg, v.ovf, v.dz});
  endtask

  initial begin
    int dn;
    vecs[0]  = '{2'b00, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0, 15, 1'b0};
    vecs[1]  = '{2'b01, 12'h100, 12'h250, 12'h150, 1'b1, 1'b0, 1'b0, 15, 1'b0};
    vecs[2]  = '{2'b01, 12'h777, 12'h777, 12'h000, 1'b0, 1'b0, 1'b0, 15, 1'b0};
    vecs[3]  = '{2'b10, 12'h025, 12'h040, 12'h000, 1'b0, 1'b1, 1'b0, 24, 1'b0};
    vecs[4]  = '{2'b10, 12'h037, 12'h027, 12'h999, 1'b0, 1'b0, 1'b0, 24, 1'b0};
    vecs[5]  = '{2'b11, 12'h999, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 24, 1'b0};
    vecs[6]  = '{2'b11, 12'h999, 12'h004, 12'h249, 1'b0, 1'b0, 1'b0, 24, 1'b0};
    vecs[7]  = '{2'b11, 12'h5F3, 12'h001, 12'h593, 1'b0, 1'b0, 1'b0, 24, 1'b0};
    vecs[8]  = '{2'b00, 12'h999, 12'h001, 12'h000, 1'b0, 1'b1, 1'b0, 15, 1'b0};
    vecs[9]  = '{2'b00, 12'h500, 12'h499, 12'h999, 1'b0, 1'b0, 1'b0, 15, 1'b0};
    vecs[10] = '{2'b01, 12'h250, 12'h100, 12'h150, 1'b0, 1'b0, 1'b0, 15, 1'b0};
    vecs[11] = '{2'b00, 12'h100, 12'h0F9, 12'h199, 1'b0, 1'b0, 1'b0, 15, 1'b0};
    vecs[12] = '{2'b11, 12'h007, 12'h002, 12'h003, 1'b0, 1'b0, 1'b0, 24, 1'b0};
    vecs[13] = '{2'b10, 12'h037, 12'h027, 12'h999, 1'b0, 1'b0, 1'b0, 24, 1'b1};

    reset   = 1'b1;
    execute = 1'b0;
    op_code = 2'b00;
    {a100, a10, a1} = 12'h000;
    {b100, b10, b1} = 12'h000;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset result", {20'd0, r100, r10, r1}, 32'd0);
    chk("reset flags_busy_done", {27'd0, negative, overflow, div_zero, busy, done}, 32'd0);

    // Reset and execute together: reset wins, nothing starts.
    @(posedge clock); #1;
    reset = 1'b1; execute = 1'b1; op_code = 2'b00;
    {a100, a10, a1} = 12'h111;
    {b100, b10, b1} = 12'h222;
    @(posedge clock); #1;
    reset = 1'b0; execute = 1'b0;
    dn = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) dn++;
      @(posedge clock); #1;
    end
    chk("reset_over_execute idle", dn, 0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Divide aborted by reset in cycle 10; outputs held 999 beforehand.
    @(posedge clock); #1;
    op_code = 2'b11;
    {a100, a10, a1} = 12'h999;
    {b100, b10, b1} = 12'h004;
    execute = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      execute = 1'b0;
      if (c == 10) reset = 1'b1;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort result_zero", {20'd0, r100, r10, r1}, 32'd0);
    chk("abort flags_busy_done", {27'd0, negative, overflow, div_zero, busy, done}, 32'd0);
    dn = 0;
    for (int c = 12; c <= 40; c++) begin
      @(negedge clock);
      if (done === 1'b1) dn++;
    end
    chk("abort no_done", dn, 0);

    run_vec(100, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
